mem_sequencer: RTL and testbench

Parametrised block-RAM playback engine: holds a DATA_W x 2**ADDR_W memory loaded through a write port and streams a programmable address range out over a valid/ready interface. It runs one-shot or looping, and wraps around the top of memory. It sits between the debug/control plane (VIO-driven start/stop/config, host load) and downstream consumers and ILA probes. It replaces the free-running 8x8 address-counter reader.

---
 rtl/mem_sequencer.sv | 169 ++++++++++++++++
 tb/tb_mem_sequencer.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_sequencer.sv
// mem_sequencer: block-RAM playback engine. A host loads the memory through
// the write port. A start command then streams the address range
// start_addr..end_addr (wrapping modulo depth) out over a valid/ready port.
// Playback can run once or loop, and can be aborted with stop.
//
// Handshake: a word moves when out_valid && out_ready are both high at a
// rising edge. out_valid depends only on registered FIFO occupancy and never
// on out_ready. Once raised, out_valid stays high with stable out_data until
// that word transfers, unless stop or reset flushes the buffer.
module mem_sequencer #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_en,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] end_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] cur_addr,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    // Storage; deliberately not cleared by reset.
    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    state_t            state_q;
    logic [ADDR_W-1:0] start_q;
    logic [ADDR_W-1:0] end_q;
    logic [ADDR_W-1:0] cur_addr_q;
    logic              busy_q;
    logic              done_q;

    // Two-entry output buffer. fifo0 is always the head word.
    logic [DATA_W-1:0] fifo0_q, fifo0_d;
    logic [DATA_W-1:0] fifo1_q, fifo1_d;
    logic [1:0]        count_q, count_d;

    logic              xfer;
    logic              issue;
    logic [1:0]        occ_after_pop;
    logic [DATA_W-1:0] rd_word;

    // The read issued in a cycle lands in the buffer at the closing edge.
    // So nothing is ever in flight between edges, and the occupancy test
    // only needs the current count less this cycle's pop.
    assign xfer          = (count_q != 2'd0) && out_ready;
    assign occ_after_pop = count_q - {1'b0, xfer};
    assign issue         = (state_q == ST_PLAY) && !stop && (occ_after_pop <= 2'd1);
    assign rd_word       = mem_q[cur_addr_q];

    // Host write port. Reads sample the array before this update, so a
    // read and a write to the same address return the old word.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Next buffer contents: pop the head first, then append the read word.
    always_comb begin
        fifo0_d = fifo0_q;
        fifo1_d = fifo1_q;
        count_d = count_q;
        if (xfer) begin
            fifo0_d = fifo1_q;
            count_d = count_q - 2'd1;
        end
        if (issue) begin
            if (count_d == 2'd0) begin
                fifo0_d = rd_word;
            end else begin
                fifo1_d = rd_word;
            end
            count_d = count_d + 2'd1;
        end
    end

    // Playback FSM, address sequencing and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            start_q    <= '0;
            end_q      <= '0;
            cur_addr_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            fifo0_q    <= '0;
            fifo1_q    <= '0;
            count_q    <= 2'd0;
        end else begin
            done_q  <= 1'b0;
            fifo0_q <= fifo0_d;
            fifo1_q <= fifo1_d;
            count_q <= count_d;
            case (state_q)
                ST_IDLE: begin
                    if (start && !stop) begin
                        start_q    <= start_addr;
                        end_q      <= end_addr;
                        cur_addr_q <= start_addr;
                        busy_q     <= 1'b1;
                        state_q    <= ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    if (stop) begin
                        count_q <= 2'd0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (issue) begin
                        if (cur_addr_q == end_q) begin
                            // loop_en matters only at the end of a pass.
                            if (loop_en) begin
                                cur_addr_q <= start_q;
                            end else begin
                                cur_addr_q <= cur_addr_q + ADDR_ONE;
                                state_q    <= ST_FLUSH;
                            end
                        end else begin
                            cur_addr_q <= cur_addr_q + ADDR_ONE;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (stop) begin
                        count_q <= 2'd0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (xfer && (count_q == 2'd1)) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    count_q <= 2'd0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign out_data  = fifo0_q;
    assign out_valid = (count_q != 2'd0);
    assign busy      = busy_q;
    assign done      = done_q;
    assign cur_addr  = cur_addr_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_sequencer.sv
// Testbench for mem_sequencer: scenario tasks compare DUT outputs against a
// memory image and expected-word queue kept by the bench.
module tb_mem_sequencer;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic       start;
    logic       stop;
    logic       loop_en;
    logic [2:0] start_addr;
    logic [2:0] end_addr;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic       done;
    logic [2:0] cur_addr;
    logic [1:0] dbg_state;

    int checks = 0;
    int errors = 0;

    logic [7:0] model_mem [DEPTH];
    logic [7:0] exp_q[$];

    mem_sequencer #(.DATA_W(8), .ADDR_W(3)) dut (
        .clk(clk),
        .reset(reset),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .start(start),
        .stop(stop),
        .loop_en(loop_en),
        .start_addr(start_addr),
        .end_addr(end_addr),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .busy(busy),
        .done(done),
        .cur_addr(cur_addr),
        .dbg_state(dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected stream for one pass over s..e, wrapping through the top.
    task automatic build_exp(input logic [2:0] s, input logic [2:0] e);
        logic [2:0] diff;
        logic [2:0] a;
        int n;
        exp_q.delete();
        diff = e - s;
        n = int'(diff) + 1;
        a = s;
        for (int k = 0; k < n; k++) begin
            exp_q.push_back(model_mem[a]);
            a = a + 3'd1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", out_valid); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h exp 00", out_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b exp 0", done); end
        checks++; if (cur_addr !== 3'd0) begin errors++; $display("FAIL reset_cur_addr: got %0d exp 0", cur_addr); end
        checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d exp 0", dbg_state); end
    endtask

    task automatic load_mem();
        for (int i = 0; i < DEPTH; i++) begin
            wr_en = 1'b1;
            wr_addr = 3'(i);
            wr_data = 8'(16 + i);
            model_mem[i] = 8'(16 + i);
            step();
        end
        wr_en = 1'b0;
    endtask

    // One-shot pass with out_ready held high; checks exact cycle timing.
    task automatic test_range(input logic [2:0] s, input logic [2:0] e);
        int n;
        logic [7:0] w;
        build_exp(s, e);
        n = exp_q.size();
        start_addr = s;
        end_addr = e;
        loop_en = 1'b0;
        out_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= n + 3; c++) begin
            if (c <= n + 1) begin
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL range_busy s=%0d e=%0d cyc %0d: got %b exp 1", s, e, c, busy); end
            end
            if (c == 1) begin
                checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL range_first_valid s=%0d e=%0d: got %b exp 0", s, e, out_valid); end
                checks++; if (cur_addr !== s) begin errors++; $display("FAIL range_cur_addr s=%0d e=%0d: got %0d exp %0d", s, e, cur_addr, s); end
            end else if (c <= n + 1) begin
                w = exp_q.pop_front();
                checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL range_valid s=%0d e=%0d cyc %0d: got %b exp 1", s, e, c, out_valid); end
                checks++; if (out_data !== w) begin errors++; $display("FAIL range_data s=%0d e=%0d cyc %0d: got %h exp %h", s, e, c, out_data, w); end
                checks++; if (done !== 1'b0) begin errors++; $display("FAIL range_early_done s=%0d e=%0d cyc %0d: got %b exp 0", s, e, c, done); end
            end else if (c == n + 2) begin
                checks++; if (done !== 1'b1) begin errors++; $display("FAIL range_done s=%0d e=%0d: got %b exp 1", s, e, done); end
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL range_busy_fall s=%0d e=%0d: got %b exp 0", s, e, busy); end
                checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL range_end_valid s=%0d e=%0d: got %b exp 0", s, e, out_valid); end
            end else begin
                checks++; if (done !== 1'b0) begin errors++; $display("FAIL range_done_pulse s=%0d e=%0d: got %b exp 0", s, e, done); end
            end
            if (c < n + 3) step();
        end
    endtask

    // Backpressure: fill with ready low, then random ready until done.
    task automatic test_backpressure();
        logic [7:0] w;
        logic got_done;
        build_exp(3'd0, 3'd7);
        start_addr = 3'd0;
        end_addr = 3'd7;
        loop_en = 1'b0;
        out_ready = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (6) step();
        checks++; if (cur_addr !== 3'd2) begin errors++; $display("FAIL bp_fill_reads: cur_addr got %0d exp 2", cur_addr); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_fill_valid: got %b exp 1", out_valid); end
        checks++; if (out_data !== exp_q[0]) begin errors++; $display("FAIL bp_fill_head: got %h exp %h", out_data, exp_q[0]); end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            w = exp_q.pop_front();
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_resume_bubble %0d: got %b exp 1", i, out_valid); end
            checks++; if (out_data !== w) begin errors++; $display("FAIL bp_resume_data %0d: got %h exp %h", i, out_data, w); end
            step();
        end
        got_done = 1'b0;
        for (int c = 0; c < 200 && !got_done; c++) begin
            out_ready = 1'($urandom_range(0, 1));
            if (done === 1'b1) begin
                got_done = 1'b1;
            end else if (out_valid === 1'b1 && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL bp_extra_word: got %h exp none", out_data);
                end else begin
                    w = exp_q.pop_front();
                    checks++; if (out_data !== w) begin errors++; $display("FAIL bp_data: got %h exp %h", out_data, w); end
                end
            end
            if (!got_done) step();
        end
        checks++; if (got_done !== 1'b1) begin errors++; $display("FAIL bp_done: got %b exp 1", got_done); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL bp_missing: got %0d left exp 0", exp_q.size()); end
        out_ready = 1'b1;
    endtask

    // Looping over 2..4; loop_en drops at the start of the fourth pass.
    task automatic test_loop();
        logic [7:0] w;
        logic got_done;
        int xfers;
        start_addr = 3'd2;
        end_addr = 3'd4;
        loop_en = 1'b1;
        out_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        xfers = 0;
        got_done = 1'b0;
        for (int c = 0; c < 60 && !got_done; c++) begin
            if (done === 1'b1) begin
                got_done = 1'b1;
            end else begin
                if (out_valid === 1'b1) begin
                    w = model_mem[2 + (xfers % 3)];
                    checks++; if (out_data !== w) begin errors++; $display("FAIL loop_data word %0d: got %h exp %h", xfers, out_data, w); end
                    xfers++;
                    if (xfers == 10) loop_en = 1'b0;
                end
                step();
            end
        end
        checks++; if (got_done !== 1'b1) begin errors++; $display("FAIL loop_done: got %b exp 1", got_done); end
        checks++; if (xfers != 12) begin errors++; $display("FAIL loop_count: got %0d exp 12", xfers); end
        loop_en = 1'b0;
    endtask

    // stop after three transfers.
    task automatic test_stop();
        logic [7:0] w;
        int xfers;
        build_exp(3'd0, 3'd7);
        start_addr = 3'd0;
        end_addr = 3'd7;
        out_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        xfers = 0;
        for (int c = 0; c < 20 && xfers < 3; c++) begin
            if (out_valid === 1'b1) begin
                w = exp_q.pop_front();
                checks++; if (out_data !== w) begin errors++; $display("FAIL stop_data %0d: got %h exp %h", xfers, out_data, w); end
                xfers++;
            end
            if (xfers == 3) stop = 1'b1;
            step();
        end
        stop = 1'b0;
        checks++; if (xfers != 3) begin errors++; $display("FAIL stop_xfers: got %0d exp 3", xfers); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stop_valid: got %b exp 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stop_busy: got %b exp 0", busy); end
        checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL stop_state: got %0d exp 0", dbg_state); end
        for (int c = 0; c < 4; c++) begin
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL stop_no_done cyc %0d: got %b exp 0", c, done); end
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stop_quiet cyc %0d: got %b exp 0", c, out_valid); end
            step();
        end
    endtask

    task automatic test_start_stop_idle();
        start_addr = 3'd0;
        end_addr = 3'd7;
        start = 1'b1;
        stop = 1'b1;
        step();
        start = 1'b0;
        stop = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ss_busy: got %b exp 0", busy); end
        checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL ss_state: got %0d exp 0", dbg_state); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ss_valid: got %b exp 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ss_busy_later: got %b exp 0", busy); end
    endtask

    // Write mem[5] before it is read; a start while busy must be ignored.
    task automatic test_write_during_play();
        logic [7:0] w;
        start_addr = 3'd0;
        end_addr = 3'd7;
        out_ready = 1'b1;
        start = 1'b1;
        step();
        wr_en = 1'b1;
        wr_addr = 3'd5;
        wr_data = 8'hAA;
        model_mem[5] = 8'hAA;
        start = 1'b1;
        start_addr = 3'd3;
        end_addr = 3'd3;
        build_exp(3'd0, 3'd7);
        step();
        wr_en = 1'b0;
        start = 1'b0;
        for (int c = 2; c <= 9; c++) begin
            w = exp_q.pop_front();
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL wr_valid cyc %0d: got %b exp 1", c, out_valid); end
            checks++; if (out_data !== w) begin errors++; $display("FAIL wr_data cyc %0d: got %h exp %h", c, out_data, w); end
            step();
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL wr_done: got %b exp 1", done); end
        step();
    endtask

    // Reset asserted during cycle 4 of a playback.
    task automatic test_reset_mid();
        logic [7:0] w;
        build_exp(3'd0, 3'd7);
        start_addr = 3'd0;
        end_addr = 3'd7;
        out_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            if (c >= 2) begin
                w = exp_q.pop_front();
                checks++; if (out_data !== w) begin errors++; $display("FAIL rm_data cyc %0d: got %h exp %h", c, out_data, w); end
            end
            if (c == 4) reset = 1'b1;
            step();
        end
        reset = 1'b0;
        test_reset();
    endtask

    initial begin
        reset = 1'b1;
        wr_en = 1'b0;
        wr_addr = 3'd0;
        wr_data = 8'h00;
        start = 1'b0;
        stop = 1'b0;
        loop_en = 1'b0;
        start_addr = 3'd0;
        end_addr = 3'd0;
        out_ready = 1'b0;
        do_reset();
        test_reset();
        load_mem();
        test_range(3'd0, 3'd7);
        test_range(3'd6, 3'd1);
        test_range(3'd3, 3'd3);
        test_backpressure();
        test_loop();
        test_stop();
        test_start_stop_idle();
        test_write_during_play();
        test_reset_mid();
        test_range(3'd0, 3'd7);
        test_range(3'd5, 3'd2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
